// File: rtl/exception_controller.sv
// exception_controller: single-level exception entry/return sequencer.
// Captures ELR/ESR on an exception, then redirects fetch to the vector and later to ELR.
module exception_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        ExtIRQ,
  input  logic        ExcInvOp_M,
  input  logic        Eret_M,
  input  logic [63:0] PC_M,
  input  logic [63:0] NextPC_F,
  output logic        EProc_F,
  output logic        ERetSel_F,
  output logic [63:0] ERetAddr_F,
  output logic        Flush,
  output logic [63:0] ELR,
  output logic [3:0]  ESR,
  output logic        ExcActive,
  output logic [7:0]  ExcCount
);
  typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RETURN} state_t;
  state_t state, state_nxt;
  logic irq_mask, take_inv, take_irq;
  always_comb begin
    take_inv  = state == IDLE && ExcInvOp_M;
    take_irq  = state == IDLE && !ExcInvOp_M && ExtIRQ && !irq_mask;
    state_nxt = (take_inv || take_irq) ? ENTER :
                state == ENTER ? HANDLER :
                (state == HANDLER && Eret_M) ? RETURN :
                state == RETURN ? IDLE : state;
    EProc_F   = state == ENTER;
    ERetSel_F = state == RETURN;
    Flush     = state == ENTER || state == RETURN;
    ExcActive = state == HANDLER;
  end
  assign ERetAddr_F = ELR;
  // irq_mask covers the first IDLE cycle after RETURN so the return target gets fetched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      irq_mask <= 1'b0;
      ELR      <= 64'h0;
      ESR      <= 4'h0;
      ExcCount <= 8'h0;
    end else begin
      state    <= state_nxt;
      irq_mask <= state == RETURN;
      if (take_inv || take_irq) begin
        ELR      <= take_inv ? PC_M : NextPC_F;
        ESR      <= take_inv ? 4'b0010 : 4'b0001;
        ExcCount <= ExcCount + {7'd0, ExcCount != 8'hFF};
      end
    end
  end
endmodule

// File: tb/tb_exception_controller.sv
// tb_exception_controller: directed vectors against hand-computed expectations.
module tb_exception_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ExtIRQ = 1'b0, ExcInvOp_M = 1'b0, Eret_M = 1'b0;
  logic [63:0] PC_M = 64'h0, NextPC_F = 64'h0;
  logic        EProc_F, ERetSel_F, Flush, ExcActive;
  logic [63:0] ERetAddr_F, ELR;
  logic [3:0]  ESR;
  logic [7:0]  ExcCount;
  int n_run = 0, n_fail = 0;

  exception_controller dut (
    .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .ExcInvOp_M(ExcInvOp_M),
    .Eret_M(Eret_M), .PC_M(PC_M), .NextPC_F(NextPC_F), .EProc_F(EProc_F),
    .ERetSel_F(ERetSel_F), .ERetAddr_F(ERetAddr_F), .Flush(Flush), .ELR(ELR),
    .ESR(ESR), .ExcActive(ExcActive), .ExcCount(ExcCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_eproc", EProc_F, 0);
    chk("rst_eretsel", ERetSel_F, 0);
    chk("rst_flush", Flush, 0);
    chk("rst_active", ExcActive, 0);
    chk("rst_elr", ELR, 0);
    chk("rst_esr", ESR, 0);
    chk("rst_cnt", ExcCount, 0);
    #20 reset = 1'b1;
    cyc();
    // invalid opcode entry
    ExcInvOp_M = 1; PC_M = 64'h40;
    cyc();
    ExcInvOp_M = 0;
    chk("inv_eproc", EProc_F, 1);
    chk("inv_flush", Flush, 1);
    chk("inv_eretsel", ERetSel_F, 0);
    chk("inv_elr", ELR, 64'h40);
    chk("inv_esr", ESR, 4'b0010);
    chk("inv_cnt", ExcCount, 1);
    cyc();
    chk("inv_active", ExcActive, 1);
    chk("inv_eproc_off", EProc_F, 0);
    chk("inv_flush_off", Flush, 0);
    // nesting ignored
    ExcInvOp_M = 1; ExtIRQ = 1; PC_M = 64'h99; NextPC_F = 64'h77;
    cyc();
    ExcInvOp_M = 0; ExtIRQ = 0;
    chk("nest_active", ExcActive, 1);
    chk("nest_eproc", EProc_F, 0);
    chk("nest_elr", ELR, 64'h40);
    chk("nest_esr", ESR, 4'b0010);
    chk("nest_cnt", ExcCount, 1);
    // return
    Eret_M = 1;
    cyc();
    Eret_M = 0;
    chk("ret_eretsel", ERetSel_F, 1);
    chk("ret_flush", Flush, 1);
    chk("ret_eproc", EProc_F, 0);
    chk("ret_addr", ERetAddr_F, 64'h40);
    cyc();
    chk("ret_idle_sel", ERetSel_F, 0);
    chk("ret_idle_active", ExcActive, 0);
    chk("ret_hold_elr", ELR, 64'h40);
    chk("ret_hold_esr", ESR, 4'b0010);
    // Eret in IDLE ignored
    Eret_M = 1;
    cyc();
    Eret_M = 0;
    chk("idle_eret_sel", ERetSel_F, 0);
    chk("idle_eret_flush", Flush, 0);
    // IRQ entry and return
    ExtIRQ = 1; NextPC_F = 64'h88;
    cyc();
    ExtIRQ = 0;
    chk("irq_eproc", EProc_F, 1);
    chk("irq_elr", ELR, 64'h88);
    chk("irq_esr", ESR, 4'b0001);
    chk("irq_cnt", ExcCount, 2);
    cyc();
    Eret_M = 1;
    cyc();
    Eret_M = 0;
    chk("irq_ret_sel", ERetSel_F, 1);
    chk("irq_ret_addr", ERetAddr_F, 64'h88);
    chk("irq_ret_flush", Flush, 1);
    cyc();
    chk("irq_ret_idle", ERetSel_F, 0);
    // simultaneous events; IRQ held through return
    ExcInvOp_M = 1; ExtIRQ = 1; PC_M = 64'h10; NextPC_F = 64'h200;
    cyc();
    ExcInvOp_M = 0;
    chk("sim_esr", ESR, 4'b0010);
    chk("sim_elr", ELR, 64'h10);
    chk("sim_cnt", ExcCount, 3);
    cyc();
    Eret_M = 1;
    cyc();
    Eret_M = 0;
    chk("sim_ret_sel", ERetSel_F, 1);
    cyc();
    chk("sim_idle1_eproc", EProc_F, 0);
    cyc();
    chk("sim_idle2_eproc", EProc_F, 0);
    chk("sim_idle2_esr", ESR, 4'b0010);
    cyc();
    ExtIRQ = 0;
    chk("sim_reentry_eproc", EProc_F, 1);
    chk("sim_reentry_esr", ESR, 4'b0001);
    chk("sim_reentry_elr", ELR, 64'h200);
    cyc();
    chk("sim_handler", ExcActive, 1);
    // asynchronous reset mid-HANDLER
    #2 reset = 0;
    #1;
    chk("mid_rst_active", ExcActive, 0);
    chk("mid_rst_elr", ELR, 0);
    chk("mid_rst_esr", ESR, 0);
    chk("mid_rst_cnt", ExcCount, 0);
    cyc();
    #2 reset = 1;
    Eret_M = 1;
    cyc();
    Eret_M = 0;
    chk("mid_rst_eretsel", ERetSel_F, 0);
    chk("mid_rst_flush", Flush, 0);
    // reset in the masked IDLE cycle clears the mask
    ExcInvOp_M = 1; PC_M = 64'h20;
    cyc();
    ExcInvOp_M = 0;
    cyc();
    Eret_M = 1;
    cyc();
    Eret_M = 0;
    cyc();
    #2 reset = 0;
    #2 reset = 1;
    ExtIRQ = 1; NextPC_F = 64'h300;
    cyc();
    ExtIRQ = 0;
    chk("mask_rst_eproc", EProc_F, 1);
    chk("mask_rst_elr", ELR, 64'h300);
    cyc();
    Eret_M = 1;
    cyc();
    Eret_M = 0;
    cyc();
    // saturation: count is 1 here, 255 more entries reach 256 total
    for (int i = 0; i < 255; i++) begin
      ExcInvOp_M = 1; PC_M = 64'h1000;
      cyc();
      ExcInvOp_M = 0;
      cyc();
      Eret_M = 1;
      cyc();
      Eret_M = 0;
      cyc();
    end
    chk("sat_cnt", ExcCount, 8'hFF);
    ExcInvOp_M = 1; PC_M = 64'h2000;
    cyc();
    ExcInvOp_M = 0;
    chk("sat_eproc", EProc_F, 1);
    chk("sat_cnt_hold", ExcCount, 8'hFF);
    chk("sat_elr", ELR, 64'h2000);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and reset as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 ExtIRQ  input  1  external interrupt request, level-sensitive.
REQ-005 ExcInvOp_M  input  1  invalid-opcode detected for the instruction in the memory stage.
REQ-006 Eret_M  input  1  ERET instruction in the memory stage.
REQ-007 PC_M  input  64  PC of the instruction in the memory stage.
REQ-008 NextPC_F  input  64  next sequential or branch PC from fetch.
REQ-009 EProc_F  output  1  redirects fetch to the exception vector 0xD8.
REQ-010 ERetSel_F  output  1  redirects fetch to ERetAddr_F.
REQ-011 ERetAddr_F  output  64  return target, equal to ELR.
REQ-012 Flush  output  1  flushes the IF/ID, ID/EX and EX/MEM registers.
REQ-013 ELR  output  64  exception link register.
REQ-014 ESR  output  4  exception syndrome: 0000 none, 0001 IRQ, 0010 invalid opcode.
REQ-015 ExcActive  output  1  high while in HANDLER.
REQ-016 ExcCount  output  8  count of exceptions taken; saturates at 8'hFF.

Function
REQ-017 The FSM SHALL have four states, IDLE, ENTER, HANDLER and RETURN, with all transitions on the rising edge of clk.
REQ-018 In IDLE with ExcInvOp_M=1, the block SHALL capture ELR<=PC_M and ESR<=0010, then move to ENTER.
REQ-019 In IDLE with ExcInvOp_M=0 and ExtIRQ=1, the block SHALL capture ELR<=NextPC_F and ESR<=0001, then move to ENTER.
REQ-020 When ExcInvOp_M and ExtIRQ are both high, the invalid opcode SHALL win; the IRQ stays pending only while ExtIRQ is held.
REQ-021 In IDLE, Eret_M SHALL be ignored with no output change.
REQ-022 ENTER SHALL assert EProc_F=1 and Flush=1 for exactly one cycle, increment ExcCount (saturating), and then move to HANDLER.
REQ-023 In HANDLER, ExcActive SHALL be 1; ExcInvOp_M and ExtIRQ are ignored (no nesting), and ELR and ESR hold their values.
REQ-024 In HANDLER, Eret_M=1 SHALL cause a move to RETURN.
REQ-025 RETURN SHALL assert ERetSel_F=1 and Flush=1 for exactly one cycle, then move to IDLE.
REQ-026 ESR and ELR SHALL keep their values after RETURN until the next capture.
REQ-027 In the first IDLE cycle after RETURN, ExtIRQ SHALL be masked so that at least one handler-return instruction is fetched; ExcInvOp_M is not masked.
REQ-028 ERetAddr_F SHALL equal ELR combinationally at all times.
REQ-029 EProc_F, ERetSel_F and Flush SHALL be registered-state decodes (Moore outputs) and SHALL never be high together with each other's redirect.
REQ-030 EProc_F and ERetSel_F SHALL never be high in the same cycle.
REQ-031 Entry latency SHALL be one cycle: an exception event sampled at edge N gives EProc_F=1 during cycle N+1.
REQ-032 Return latency SHALL be one cycle: Eret_M sampled at edge N gives ERetSel_F=1 during cycle N+1.
REQ-033 ExcCount SHALL stay at 8'hFF once saturated; further entries still proceed normally.

Reset
REQ-034 When reset=0, the block SHALL immediately, without waiting for clk, set state IDLE, ELR=64'h0, ESR=4'h0, ExcCount=8'h0, and EProc_F, ERetSel_F, Flush and ExcActive to 0.
REQ-035 A reset asserted in ENTER, HANDLER or RETURN SHALL abort the sequence with no redirect pulse after reset deasserts.
REQ-036 The IRQ mask of REQ-027 SHALL be cleared by reset.

Verification
REQ-037 Invalid opcode: ExcInvOp_M=1 with PC_M=64'h40 in IDLE -> the next cycle has EProc_F=1, Flush=1, ELR=64'h40, ESR=0010, ExcCount=1; the cycle after has ExcActive=1.
REQ-038 IRQ, then return: ExtIRQ=1 with NextPC_F=64'h88 -> ELR=64'h88 and ESR=0001; later Eret_M=1 -> one cycle of ERetSel_F=1 with ERetAddr_F=64'h88 and Flush=1, then IDLE.
REQ-039 Simultaneous events: ExcInvOp_M=1, ExtIRQ=1, PC_M=64'h10 -> ESR=0010 and ELR=64'h10; ExtIRQ held through the return -> re-entry with ESR=0001 no earlier than the second IDLE cycle.
REQ-040 Nesting ignored: in HANDLER, pulse ExcInvOp_M and ExtIRQ -> ELR, ESR and ExcCount unchanged and no EProc_F pulse.
REQ-041 Mid-operation reset: reset=0 during HANDLER, between clock edges -> outputs clear immediately; after release, Eret_M=1 gives no ERetSel_F.
REQ-042 Saturation: take 256 exceptions back-to-back (enter and return) -> ExcCount=8'hFF, and the 257th entry still pulses EProc_F.
